// File: rtl/tick_generator.sv
// tick_generator: multi-channel, runtime-reprogrammable clock-enable generator.
// Optional 8-phase one-hot output of channel 0 is built only with `TICK_PHASE_OUT_EN.
module tick_generator #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 25175000
) (
  input  logic                clkIn,
  input  logic                rstN,
  input  logic                en,
  input  logic [CHANNELS-1:0] loadDiv,
  input  logic [CNT_W-1:0]    divIn,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clkOut,
  output logic [7:0]          phase
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]    cnt    [CHANNELS];
  logic [CNT_W-1:0]    divReg [CHANNELS];
  logic [CNT_W-1:0]    dEff   [CHANNELS];
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] high;

  // Zero divisor behaves as 1; end-of-period and square-wave compares
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      dEff[i] = (divReg[i] == '0) ? ONE : divReg[i];
      wrap[i] = cnt[i] >= (dEff[i] - ONE);
      high[i] = cnt[i] < (dEff[i] >> 1);
    end
  end

  // Per-channel counter, divisor register and registered outputs
  always_ff @(posedge clkIn) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rstN) begin
        cnt[i]    <= '0;
        divReg[i] <= DIV_RST;
        tick[i]   <= 1'b0;
        clkOut[i] <= 1'b0;
      end else if (loadDiv[i]) begin
        cnt[i]    <= '0;
        divReg[i] <= divIn;
        tick[i]   <= 1'b0;
        clkOut[i] <= 1'b0;
      end else if (en) begin
        cnt[i]    <= wrap[i] ? '0 : cnt[i] + ONE;
        tick[i]   <= wrap[i];
        clkOut[i] <= high[i];
      end else begin
        tick[i]   <= 1'b0;
      end
    end
  end

`ifdef TICK_PHASE_OUT_EN
  localparam int unsigned PW = CNT_W + 4;

  logic [PW-1:0] scaled;
  logic [8:0]    ge;
  logic [7:0]    phaseNext;

  // Octant of channel 0: k with k*d <= 8*cnt < (k+1)*d, bit 7-k set
  always_comb begin
    scaled = {1'b0, cnt[0], 3'b000};
    for (int k = 0; k < 9; k++) begin
      ge[k] = scaled >= (PW'(k) * PW'(dEff[0]));
    end
    for (int k = 0; k < 8; k++) begin
      phaseNext[7-k] = ge[k] & ~ge[k+1];
    end
  end

  // Phase register follows channel 0 load/enable rules
  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      phase <= '0;
    end else if (loadDiv[0]) begin
      phase <= '0;
    end else if (en) begin
      phase <= phaseNext;
    end
  end
`else
  assign phase = 8'b0;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: randomized bench for tick_generator against a
// period-arithmetic reference model (enabled edges modulo divisor).
module tb_tick_generator;

  localparam int CH  = 4;
  localparam int W   = 32;
  localparam int DEF = 4;

  logic          clkIn = 1'b0;
  logic          rstN;
  logic          en;
  logic [CH-1:0] loadDiv;
  logic [W-1:0]  divIn;
  logic [CH-1:0] tick;
  logic [CH-1:0] clkOut;
  logic [7:0]    phase;

  tick_generator #(
    .CHANNELS   (CH),
    .CNT_W      (W),
    .DIV_DEFAULT(DEF)
  ) dut (
    .clkIn  (clkIn),
    .rstN   (rstN),
    .en     (en),
    .loadDiv(loadDiv),
    .divIn  (divIn),
    .tick   (tick),
    .clkOut (clkOut),
    .phase  (phase)
  );

  always #5 clkIn = ~clkIn;

  int errors = 0;
  int checks = 0;

  longint unsigned mDiv [CH];
  longint unsigned mN   [CH];
  logic [CH-1:0]   mTick;
  logic [CH-1:0]   mClk;
  logic [7:0]      mPhase;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned effDiv(longint unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  // Reference: position in period = enabled edges since load/reset mod d
  task automatic modelEdge();
    longint unsigned d, c;
    if (!rstN) begin
      for (int i = 0; i < CH; i++) begin
        mDiv[i] = DEF;
        mN[i]   = 0;
      end
      mTick  = '0;
      mClk   = '0;
      mPhase = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        d = effDiv(mDiv[i]);
        if (loadDiv[i]) begin
          mDiv[i]  = divIn;
          mN[i]    = 0;
          mTick[i] = 1'b0;
          mClk[i]  = 1'b0;
          if (i == 0) mPhase = '0;
        end else if (en) begin
          c        = mN[i] % d;
          mTick[i] = (c == d - 1);
          mClk[i]  = (c < d / 2);
          if (i == 0) mPhase = 8'h80 >> ((8 * c) / d);
          mN[i]++;
        end else begin
          mTick[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(string tag);
    logic [7:0] expPh;
    @(posedge clkIn);
    modelEdge();
    @(negedge clkIn);
`ifdef TICK_PHASE_OUT_EN
    expPh = mPhase;
`else
    expPh = 8'h00;
`endif
    check({tag, ".tick"}, 32'(tick), 32'(mTick));
    check({tag, ".clkOut"}, 32'(clkOut), 32'(mClk));
    check({tag, ".phase"}, 32'(phase), 32'(expPh));
  endtask

  task automatic idle(string tag, int n);
    for (int j = 0; j < n; j++) step(tag);
  endtask

  int cntT;
  int lat;

  initial begin
    rstN    = 1'b0;
    en      = 1'b1;
    loadDiv = 4'b1111;
    divIn   = 32'd7;
    idle("reset", 3);

    // Divisor 4 from reset: tick 1-in-4, clkOut 1,1,0,0
    rstN    = 1'b1;
    loadDiv = '0;
    cntT    = 0;
    for (int j = 0; j < 20; j++) begin
      step("t1");
      cntT += int'(tick[0]);
    end
    check("t1.tickCount", 32'(cntT), 32'd5);

    // Ch1 reloaded to 10 while ch0 keeps running
    divIn   = 32'd10;
    loadDiv = 4'b0010;
    step("t2.load");
    loadDiv = '0;
    cntT    = 0;
    for (int j = 0; j < 30; j++) begin
      step("t2");
      cntT += int'(tick[1]);
    end
    check("t2.ch1Ticks", 32'(cntT), 32'd3);

    // Ch0 at 12, reload to 3 when cnt=7
    divIn   = 32'd12;
    loadDiv = 4'b0001;
    step("t3.pre");
    loadDiv = '0;
    idle("t3.run", 7);
    divIn   = 32'd3;
    loadDiv = 4'b0001;
    step("t3.load");
    check("t3.noTickOnLoad", 32'(tick[0]), 32'd0);
    loadDiv = '0;
    lat     = 0;
    do begin
      step("t3.wait");
      lat++;
    end while (!tick[0] && lat < 20);
    check("t3.latency", 32'(lat), 32'd3);

    // Divisors 0 and 1 both behave as 1; en low freezes
    divIn   = 32'd0;
    loadDiv = 4'b0100;
    step("t4.load0");
    divIn   = 32'd1;
    loadDiv = 4'b1000;
    step("t4.load1");
    loadDiv = '0;
    idle("t4.run", 5);
    check("t4.d1tick", 32'(tick[3:2]), 32'd3);
    en = 1'b0;
    idle("t4.hold", 5);
    check("t4.holdTick", 32'(tick), 32'd0);
    en = 1'b1;
    idle("t4.resume", 8);

    // Ch0 at 16 for phase stepping
    divIn   = 32'd16;
    loadDiv = 4'b0001;
    step("t5.load");
    loadDiv = '0;
    idle("t5.run", 40);

    // Randomized traffic
    for (int j = 0; j < 3000; j++) begin
      rstN    = ($urandom_range(0, 199) != 0);
      en      = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < CH; i++)
        loadDiv[i] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0)
        divIn = $urandom;
      else
        divIn = 32'($urandom_range(0, 20));
      step("rnd");
    end

    // Reset pulse coinciding with a ch2 load: reset wins
    rstN    = 1'b1;
    en      = 1'b1;
    loadDiv = '0;
    idle("t6.pre", 6);
    rstN    = 1'b0;
    divIn   = 32'd9;
    loadDiv = 4'b0100;
    step("t6.rst");
    check("t6.zeroTick", 32'(tick), 32'd0);
    check("t6.zeroClk", 32'(clkOut), 32'd0);
    rstN    = 1'b1;
    loadDiv = '0;
    cntT    = 0;
    for (int j = 0; j < 12; j++) begin
      step("t6.run");
      cntT += int'(tick[2]);
    end
    check("t6.ch2Default", 32'(cntT), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
